// File: rtl/timer_prog.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : timer_prog
//  Brief    : Programmable interval timer with a loadable period and prescale.
//             Supports periodic and one-shot modes, pause via Enable, and
//             explicit Start/Stop. Out of reset it free-runs with a period
//             of RESET_PERIOD cycles and emits a one-cycle Rollover strobe.
//  Revision : 1.0  initial release
// ============================================================================
module timer_prog #(
    parameter int WIDTH          = 20,
    parameter int PRESCALE_WIDTH = 8,
    parameter int RESET_PERIOD   = 500000
) (
    input  logic                      clk,
    input  logic                      Reset,
    input  logic                      Enable,
    input  logic                      Mode,
    input  logic                      Start,
    input  logic                      Stop,
    input  logic                      Load,
    input  logic [WIDTH-1:0]          Period_In,
    input  logic [PRESCALE_WIDTH-1:0] Prescale_In,
    output logic                      Rollover,
    output logic [WIDTH-1:0]          Count,
    output logic                      Running,
    output logic [WIDTH-1:0]          Period
);

    // Two-state controller: RUN ticks, IDLE holds everything at zero.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0]          C_RESET_PERIOD = WIDTH'(RESET_PERIOD);
    localparam logic [WIDTH-1:0]          C_COUNT_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_WIDTH-1:0] C_PC_ONE       = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

    state_t                      state_q,    state_d;
    logic [WIDTH-1:0]            period_q,   period_d;
    logic [PRESCALE_WIDTH-1:0]   prescale_q, prescale_d;
    logic [PRESCALE_WIDTH-1:0]   pc_q,       pc_d;
    logic [WIDTH-1:0]            count_q,    count_d;
    logic                        rollover_q, rollover_d;

    logic                        w_load_ok;
    logic                        w_cmd;
    logic                        w_active;
    logic                        w_tick;
    logic                        w_terminal;

    // A zero period would never terminate, so such a load is dropped whole.
    assign w_load_ok  = Load && (Period_In != '0);
    // Any accepted command restarts timing and overrides this cycle's tick.
    assign w_cmd      = Stop || Start || w_load_ok;
    assign w_active   = (state_q == ST_RUN) && Enable;
    assign w_tick     = w_active && (pc_q == prescale_q);
    // Compare against the registered period; period_q is never zero.
    assign w_terminal = w_tick && (count_q == (period_q - C_COUNT_ONE));

    // Next-state logic: commands first, then prescaler/tick advance.
    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        prescale_d = prescale_q;
        pc_d       = pc_q;
        count_d    = count_q;
        rollover_d = 1'b0;

        if (w_cmd) begin
            count_d = '0;
            pc_d    = '0;
            if (w_load_ok) begin
                period_d   = Period_In;
                prescale_d = Prescale_In;
            end
            // Stop outranks Start; a bare Load leaves the state alone.
            if (Stop) begin
                state_d = ST_IDLE;
            end else if (Start) begin
                state_d = ST_RUN;
            end
        end else if (w_active) begin
            if (w_tick) begin
                pc_d = '0;
                if (w_terminal) begin
                    count_d    = '0;
                    rollover_d = 1'b1;
                    if (Mode) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    count_d = count_q + C_COUNT_ONE;
                end
            end else begin
                pc_d = pc_q + C_PC_ONE;
            end
        end
    end

    // State register with synchronous reset to the free-running default.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= ST_RUN;
            period_q   <= C_RESET_PERIOD;
            prescale_q <= '0;
            pc_q       <= '0;
            count_q    <= '0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            prescale_q <= prescale_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            rollover_q <= rollover_d;
        end
    end

    assign Rollover = rollover_q;
    assign Count    = count_q;
    assign Running  = (state_q == ST_RUN);
    assign Period   = period_q;

endmodule
`default_nettype wire

// File: doc/timer_prog.md
# timer_prog

Parametrised programmable interval timer for the UART design and any block needing periodic or single timing strobes. It generalises the fixed 10 ms tick: period and prescale are loadable at run time, and it supports periodic and one-shot modes, pause via enable, and explicit start/stop. Out of reset it free-runs with a period of `RESET_PERIOD` cycles, so it drops in wherever a fixed-period rollover strobe is used today.

## Interface
- `WIDTH`, 20: width of the count and period registers.
- `PRESCALE_WIDTH`, 8: width of the prescale register.
- `RESET_PERIOD`, 500000: period loaded at reset. Must satisfy 1 ≤ `RESET_PERIOD` ≤ 2^`WIDTH`−1.
- `clk`, in, 1: system clock.
- `Reset`, in, 1: reset, synchronous, active-high.
- `Enable`, in, 1: while low, ticking pauses and all state holds.
- `Mode`, in, 1: 0 = periodic, 1 = one-shot. Sampled at the terminal tick.
- `Start`, in, 1: single-cycle pulse. Enters RUN from any state, or restarts a running count.
- `Stop`, in, 1: single-cycle pulse. Returns to IDLE.
- `Load`, in, 1: single-cycle pulse. Loads `Period_In` and `Prescale_In`.
- `Period_In`, in, `WIDTH`: new period in ticks. A value of 0 is rejected.
- `Prescale_In`, in, `PRESCALE_WIDTH`: new prescale. One tick occurs every `Prescale_In`+1 clocks.
- `Rollover`, out, 1: one-cycle, registered strobe at the end of each period.
- `Count`, out, `WIDTH`: current tick count, 0 … period−1.
- `Running`, out, 1: high in the RUN state.
- `Period`, out, `WIDTH`: the active period register.

## Operation
- **Registers:** state {IDLE, RUN}, period P, prescale S, prescaler counter pc, tick count, `Rollover`.
- **Reset values:**
  - state = RUN, P = `RESET_PERIOD`, S = 0, pc = 0.
  - Outputs: `Count` = 0, `Rollover` = 0, `Running` = 1, `Period` = `RESET_PERIOD`.
- **Tick:** a tick occurs in RUN when `Enable` = 1 and pc == S. On a tick, pc → 0. Otherwise, in RUN with `Enable` = 1, pc increments.
- **Terminal tick:** a tick with `Count` == P−1. On a terminal tick, `Count` → 0 and `Rollover` → 1 on that edge. Otherwise a tick increments `Count`.
- **Mode at terminal tick:** periodic stays in RUN. One-shot moves to IDLE; `Count` and pc are 0.
- **IDLE:** `Count` and pc hold at 0. No ticks and no `Rollover`.
- **Command priority (highest first):** `Reset` > `Stop` > `Start`/`Load` > tick.
  - `Stop`: state → IDLE, `Count` → 0, pc → 0.
  - `Start`: state → RUN, `Count` → 0, pc → 0.
  - `Load` with `Period_In` ≠ 0: P ← `Period_In`, S ← `Prescale_In`, `Count` → 0, pc → 0. State is unchanged.
  - `Load` with `Period_In` = 0: ignored entirely, including S.
  - `Start` and `Load` in the same cycle: both take effect.
  - `Stop` and `Load` in the same cycle: the load takes effect and the state goes to IDLE.
- **Commands suppress the terminal tick:** any `Stop`, `Start` or accepted `Load` in the same cycle as a would-be terminal tick suppresses it. `Rollover` stays 0.
- **Enable:** commands act regardless of `Enable`. `Enable` gates only ticking.
- **Arithmetic:** unsigned. No wrap of `Count` beyond P−1. Comparison is against P−1 using the registered P.

## Timing
- `Rollover` is high for exactly one cycle, on the edge that performs the terminal tick. It is never high on two consecutive cycles unless P·(S+1) = 1.
- With `Enable` held high, the `Rollover` period is P·(S+1) clocks.
- After `Reset` deasserts, the first `Rollover` is asserted after the `RESET_PERIOD`-th active edge.
- After `Start`, `Load` or `Stop`, the new timing counts from the following edge. The first `Rollover` lands P·(S+1) edges after the command edge.
- Each cycle with `Enable` low delays the next `Rollover` by exactly one cycle.
- `Reset` mid-period: on the next edge all registers take their reset values and any pending `Rollover` is cleared.
- `Running` and `Period` are registered and update on the edge of the causing event.

## Test plan
- **Default:** release `Reset`, `Enable` = 1, no commands → `Rollover` pulses after edge 500000 and 1000000, 1 cycle wide. `Count` = 499999 the cycle before each pulse.
- **Periodic with prescale:** `Load` with `Period_In` = 4, `Prescale_In` = 2, `Mode` = 0 → `Rollover` every 12 cycles. `Count` steps 0,1,2,3 every 3 cycles.
- **One-shot:** `Load` with `Period_In` = 3, `Prescale_In` = 0, `Mode` = 1, then `Start` → a single `Rollover` 3 cycles after `Start`, then `Running` = 0 and `Count` = 0 with no further pulses. A second `Start` gives one more pulse 3 cycles later.
- **Pause:** period 5, drop `Enable` for 7 cycles at `Count` = 2 → `Count` holds at 2 and the pulse arrives 12 cycles after the previous one.
- **Command conflicts:**
  - `Stop` + `Start` together → IDLE, `Count` = 0.
  - `Start` on the terminal-tick cycle → no `Rollover`, `Count` = 0.
  - `Load` with `Period_In` = 0 → `Period` and timing unchanged.
- **Reset mid-run:** period 10, assert `Reset` at `Count` = 6 → next cycle `Count` = 0, `Rollover` = 0, `Running` = 1, `Period` = 500000.
